// File: rtl/tri_inside_test.sv
// Point-in-triangle test: edge-function sign check with one shared cross/dot datapath.
// Optional macro TRI_EARLY_EXIT_EN: finish as soon as one edge function goes negative.
module tri_inside_test #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned FRAC  = 16,
    parameter int unsigned ID_W  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_parallel,
    input  logic [ID_W-1:0]             in_id,
    input  logic [2:0][WIDTH-1:0]       p_hit,
    input  logic [2:0][WIDTH-1:0]       v0,
    input  logic [2:0][WIDTH-1:0]       v1,
    input  logic [2:0][WIDTH-1:0]       v2,
    input  logic [2:0][WIDTH-1:0]       normal,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_hit,
    output logic [ID_W-1:0]             out_id,
    output logic [2:0][WIDTH-1:0]       out_p
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned DW = WIDTH + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CROSS,
        S_DOT,
        S_DONE
    } state_t;

    state_t                  r_state;
    logic [1:0]              r_edge;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic                    r_out_hit;
    logic [ID_W-1:0]         r_out_id;
    logic [2:0][WIDTH-1:0]   r_out_p;
    logic [2:0][WIDTH-1:0]   r_p;
    logic [2:0][WIDTH-1:0]   r_v [3];
    logic [2:0][WIDTH-1:0]   r_n;
    logic [ID_W-1:0]         r_id;
    logic signed [WIDTH-1:0] r_cross [3];
`ifndef TRI_EARLY_EXIT_EN
    logic                    r_neg_any;
`endif

    logic [2:0][WIDTH-1:0]   w_va;
    logic [2:0][WIDTH-1:0]   w_vb;
    logic signed [WIDTH-1:0] w_e [3];
    logic signed [WIDTH-1:0] w_c [3];
    logic signed [WIDTH-1:0] w_x [3];
    logic signed [DW-1:0]    w_dot;
    logic                    w_neg;

    // Q-format multiply: full-width signed product, arithmetic shift by FRAC, keep low WIDTH bits.
    function automatic logic signed [WIDTH-1:0] fmul(input logic signed [WIDTH-1:0] a,
                                                     input logic signed [WIDTH-1:0] b);
        return WIDTH'((PW'(a) * PW'(b)) >>> FRAC);
    endfunction

    // Edge endpoints: 0 = v0->v1, 1 = v1->v2, 2 = v2->v0.
    always_comb begin
        w_va = r_v[0];
        w_vb = r_v[1];
        case (r_edge)
            2'd1: begin
                w_va = r_v[1];
                w_vb = r_v[2];
            end
            2'd2: begin
                w_va = r_v[2];
                w_vb = r_v[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_e[i] = WIDTH'(w_vb[i] - w_va[i]);
            w_c[i] = WIDTH'(r_p[i] - w_va[i]);
        end
        w_x[0] = WIDTH'(fmul(w_e[1], w_c[2]) - fmul(w_e[2], w_c[1]));
        w_x[1] = WIDTH'(fmul(w_e[2], w_c[0]) - fmul(w_e[0], w_c[2]));
        w_x[2] = WIDTH'(fmul(w_e[0], w_c[1]) - fmul(w_e[1], w_c[0]));
    end

    // Two guard bits keep the sign of the three-term sum exact.
    assign w_dot = DW'(fmul(r_n[0], r_cross[0]))
                 + DW'(fmul(r_n[1], r_cross[1]))
                 + DW'(fmul(r_n[2], r_cross[2]));
    assign w_neg = (w_dot < DW'(0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_edge      <= 2'd0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_hit   <= 1'b0;
            r_out_id    <= '0;
            r_out_p     <= '0;
            r_p         <= '0;
            r_v         <= '{default: '0};
            r_n         <= '0;
            r_id        <= '0;
            r_cross     <= '{default: '0};
`ifndef TRI_EARLY_EXIT_EN
            r_neg_any   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        r_in_ready <= 1'b0;
                        r_p        <= p_hit;
                        r_v[0]     <= v0;
                        r_v[1]     <= v1;
                        r_v[2]     <= v2;
                        r_n        <= normal;
                        r_id       <= in_id;
                        r_edge     <= 2'd0;
`ifndef TRI_EARLY_EXIT_EN
                        r_neg_any  <= 1'b0;
`endif
                        if (in_parallel) begin
                            // No usable p_hit: report a miss one cycle later from DONE.
                            r_out_hit <= 1'b0;
                            r_out_id  <= in_id;
                            r_out_p   <= p_hit;
                            r_state   <= S_DONE;
                        end else begin
                            r_state   <= S_CROSS;
                        end
                    end
                end
                S_CROSS: begin
                    r_cross <= w_x;
                    r_state <= S_DOT;
                end
                S_DOT: begin
`ifdef TRI_EARLY_EXIT_EN
                    if (w_neg || r_edge == 2'd2) begin
                        r_out_valid <= 1'b1;
                        r_out_hit   <= !w_neg;
                        r_out_id    <= r_id;
                        r_out_p     <= r_p;
                        r_state     <= S_DONE;
                    end else begin
                        r_edge      <= r_edge + 2'd1;
                        r_state     <= S_CROSS;
                    end
`else
                    r_neg_any <= r_neg_any | w_neg;
                    if (r_edge == 2'd2) begin
                        r_out_valid <= 1'b1;
                        r_out_hit   <= !(r_neg_any | w_neg);
                        r_out_id    <= r_id;
                        r_out_p     <= r_p;
                        r_state     <= S_DONE;
                    end else begin
                        r_edge      <= r_edge + 2'd1;
                        r_state     <= S_CROSS;
                    end
`endif
                end
                S_DONE: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_hit   = r_out_hit;
    assign out_id    = r_out_id;
    assign out_p     = r_out_p;

endmodule

// File: tb/tb_tri_inside_test.sv
// Scoreboard bench for tri_inside_test on a fixed right triangle (legs 4.0 in Q16.16).
module tb_tri_inside_test;

    typedef logic [2:0][31:0] vec_t;
    typedef struct {
        logic       hit;
        logic [7:0] id;
        vec_t       p;
        int         lat;
        int         acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_parallel = 1'b0;
    logic [7:0] in_id = '0;
    vec_t       p_hit = '0;
    vec_t       v0, v1, v2, normal;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_hit;
    logic [7:0] out_id;
    vec_t       out_p;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];

    tri_inside_test #(.WIDTH(32), .FRAC(16), .ID_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_parallel(in_parallel),
        .in_id(in_id), .p_hit(p_hit), .v0(v0), .v1(v1), .v2(v2), .normal(normal),
        .out_valid(out_valid), .out_ready(out_ready), .out_hit(out_hit),
        .out_id(out_id), .out_p(out_p)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        vec_t v;
        v[0] = x;
        v[1] = y;
        v[2] = z;
        return v;
    endfunction

    // Triangle x>=0, y>=0, x+y<=4.0 in the z=0 plane; boundary is inside.
    function automatic logic geo_hit(input vec_t p);
        logic signed [31:0] px, py;
        px = p[0];
        py = p[1];
        return (px >= 0) && (py >= 0) && (64'(longint'(px) + longint'(py)) <= 64'h40000);
    endfunction

    function automatic int exp_lat(input vec_t p, input logic par);
        logic signed [31:0] px, py;
        px = p[0];
        py = p[1];
        if (par) return 1;
`ifdef TRI_EARLY_EXIT_EN
        if (py < 0) return 2;
        if (longint'(px) + longint'(py) > 64'sh40000) return 4;
`else
        if (px + py == 32'h7fffffff) return 0;
`endif
        return 6;
    endfunction

    task automatic run_beat(input string tag, input vec_t p, input logic [7:0] id,
                            input logic par, input int hold);
        exp_t e;
        logic rdy, acc, seen;
        int   k;
        e.hit = par ? 1'b0 : geo_hit(p);
        e.id  = id;
        e.p   = p;
        e.lat = exp_lat(p, par);
        @(negedge clk);
        in_valid = 1'b1; in_parallel = par; in_id = id; p_hit = p;
        out_ready = (hold == 0);
        acc = 1'b0;
        k = 0;
        while (!acc && k < 20) begin
            rdy = in_ready;
            @(posedge clk);
            if (rdy) acc = 1'b1;
            else @(negedge clk);
            k++;
        end
        #1;
        e.acc = cyc;
        in_valid = 1'b0;
        check({tag, "_accept"}, 128'(acc), 128'(1));
        if (!acc) return;
        sb.push_back(e);
        seen = 1'b0;
        k = 0;
        while (!seen && k < 20) begin
            if (out_valid) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
            k++;
        end
        check({tag, "_valid"}, 128'(seen), 128'(1));
        if (!seen) begin
            sb.delete();
            return;
        end
        e = sb.pop_front();
        check({tag, "_lat"}, 128'(cyc - e.acc), 128'(e.lat));
        check({tag, "_hit"}, 128'(out_hit), 128'(e.hit));
        check({tag, "_id"}, 128'(out_id), 128'(e.id));
        check({tag, "_p"}, 128'(out_p), 128'(e.p));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"}, 128'(out_valid), 128'(1));
            check({tag, "_hold_hit"}, 128'(out_hit), 128'(e.hit));
            check({tag, "_hold_p"}, 128'(out_p), 128'(e.p));
            check({tag, "_hold_rdy"}, 128'(in_ready), 128'(0));
        end
        if (hold > 0) begin
            @(negedge clk);
            check({tag, "_rdy_pre_hs"}, 128'(in_ready), 128'(0));
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check({tag, "_drop"}, 128'(out_valid), 128'(0));
        check({tag, "_rdy_post"}, 128'(in_ready), 128'(1));
    endtask

    initial begin
        vec_t rp;
        v0 = mk(32'h0, 32'h0, 32'h0);
        v1 = mk(32'h40000, 32'h0, 32'h0);
        v2 = mk(32'h0, 32'h40000, 32'h0);
        normal = mk(32'h0, 32'h0, 32'h10000);

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 128'(in_ready), 128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_hit", 128'(out_hit), 128'(0));
        check("rst_out_id", 128'(out_id), 128'(0));
        check("rst_out_p", 128'(out_p), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_in_ready", 128'(in_ready), 128'(1));

        run_beat("interior", mk(32'h10000, 32'h10000, 32'h0), 8'd5, 1'b0, 0);
        run_beat("out_e1", mk(32'h30000, 32'h30000, 32'h0), 8'd6, 1'b0, 0);
        run_beat("vertex0", mk(32'h0, 32'h0, 32'h0), 8'd7, 1'b0, 0);
        run_beat("on_e1", mk(32'h20000, 32'h20000, 32'h0), 8'd8, 1'b0, 0);
        run_beat("out_e0", mk(32'h10000, 32'hffff0000, 32'h0), 8'd9, 1'b0, 0);
        run_beat("out_e2", mk(32'hffff8000, 32'h10000, 32'h0), 8'd10, 1'b0, 0);
        run_beat("parallel", mk(32'h10000, 32'h10000, 32'h0), 8'd11, 1'b1, 0);
        run_beat("backpress", mk(32'h8000, 32'h18000, 32'h0), 8'd12, 1'b0, 10);
        run_beat("after_bp", mk(32'h38000, 32'h8000, 32'h0), 8'd13, 1'b0, 0);

        for (int i = 0; i < 8; i++) begin
            rp = mk(32'($urandom_range(0, 32'h60000)) - 32'h10000,
                    32'($urandom_range(0, 32'h60000)) - 32'h10000, 32'h0);
            run_beat("random", rp, 8'(20 + i), 1'b0, 0);
        end

        // Abandon a beat while the second edge's cross product is being formed.
        @(negedge clk);
        in_valid = 1'b1; in_parallel = 1'b0; in_id = 8'd99;
        p_hit = mk(32'h10000, 32'h10000, 32'h0);
        out_ready = 1'b1;
        check("mid_rdy", 128'(in_ready), 128'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("mid_rst_valid", 128'(out_valid), 128'(0));
        check("mid_rst_rdy", 128'(in_ready), 128'(0));
        check("mid_rst_hit", 128'(out_hit), 128'(0));
        check("mid_rst_id", 128'(out_id), 128'(0));
        check("mid_rst_p", 128'(out_p), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("no_stale", 128'(out_valid), 128'(0));
        end
        run_beat("post_rst", mk(32'h10000, 32'h8000, 32'h0), 8'd42, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/tri_inside_test.md
Name: tri_inside_test

Overview:
- Stage directly downstream of the ray/plane intersection: consumes p_hit plus the triangle's vertices and normal, and decides whether p_hit lies inside the triangle.
- Uses the edge-function test: for each edge (va->vb), computes normal · ((vb-va) × (p-va)); inside iff all three are >= 0.
- Iterative with one shared cross/dot datapath, driven by an FSM; valid/ready handshake on both sides. Output feeds the closest-hit selector.

Parameters:
- WIDTH, 32, data word width; signed fixed point.
- FRAC, 16, fractional bits (Q16.16 at defaults).
- ID_W, 8, width of the triangle tag passed through with each result.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_parallel  in  1  upstream flagged normal·dir == 0 (no valid p_hit)
- in_id  in  ID_W  triangle tag
- p_hit  in  WIDTH x[2:0]  intersection point
- v0, v1, v2  in  WIDTH x[2:0] each  triangle vertices
- normal  in  WIDTH x[2:0]  triangle normal
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_hit  out  1  1 = p_hit inside or on the triangle
- out_id  out  ID_W  tag of the result
- out_p  out  WIDTH x[2:0]  registered copy of p_hit

Behaviour:
- Reset (async, rst_n=0): state IDLE, edge counter 0; in_ready=0 while in reset, 1 after release; out_valid=0, out_hit=0, out_id=0, out_p=0. Reset mid-operation abandons the beat with no output.
- States:
  - IDLE: in_ready=1. A beat is accepted on in_valid & in_ready. On accept, register p_hit, v0-v2, normal, id, and parallel; clear edge counter to 0. Next state is DONE (hit=0) if in_parallel=1, else CROSS.
  - CROSS: e = vb - va and c = p - va, both WIDTH-bit wrapping. Register the cross product e × c. Edge 0 = v0->v1, edge 1 = v1->v2, edge 2 = v2->v0.
  - DOT: d = normal · cross_reg. neg = (d < 0). If edge == 2, go to DONE with hit = all edges non-negative; else increment edge and go to CROSS.
  - DONE: out_valid=1 with out_hit/out_id/out_p stable. On out_ready, go to IDLE and drop out_valid.
- Handshake:
  - in_ready=0 in every state except IDLE; one beat in flight.
  - Once out_valid is raised, it holds until out_ready.
  - A DONE->IDLE transition and the next accept cannot share a cycle; the earliest next accept is the cycle after out_ready.
- Fixed-point multiply: full 2*WIDTH signed product, arithmetic shift right by FRAC, keep low WIDTH bits. Each cross component is a difference of two such products, WIDTH-bit wrapping.
- Dot product: sum of three FRAC-shifted products in WIDTH+2 bits, so the sign is exact for in-range data. Zero counts as inside; edges and vertices are inclusive.
- Latency from the accepting edge to out_valid=1:
  - full test: 6 edges
  - in_parallel: 1 edge

Optional Feature:
- Macro TRI_EARLY_EXIT_EN.
- Defined: in DOT, neg=1 goes straight to DONE with hit=0. Latency is 2 edges on edge-0 fail, 4 on edge-1 fail, 6 otherwise.
- Undefined: all three edges are always evaluated; latency is a fixed 6 (1 for parallel). out_hit is identical in both builds.

Test Plan:
- Common setup (Q16.16): v0=(0,0,0), v1=(0x40000,0,0), v2=(0,0x40000,0), normal=(0,0,0x10000).
- Interior: p=(0x10000,0x10000,0), id=5 -> out_valid 6 edges after accept, out_hit=1, out_id=5, out_p=p.
- Outside edge 1: p=(0x30000,0x30000,0) -> out_hit=0. Latency 6 without macro, 4 with TRI_EARLY_EXIT_EN.
- Boundary: p=v0=(0,0,0) and p=(0x20000,0x20000,0) (on edge 1) -> out_hit=1 for both.
- Parallel: in_parallel=1 with arbitrary p -> out_valid 1 edge after accept, out_hit=0.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles: out_valid and outputs stay stable, in_ready=0. Release: next beat is accepted no earlier than the following cycle.
  - Assert rst_n=0 during CROSS of edge 1: all outputs 0 immediately, no stale result after release.
